tinker_fetch_queue: RTL and testbench

- Prefetching instruction-fetch front end for the multicycle Tinker core, sitting directly upstream of the decode unit.
- Issues sequential 32-bit instruction reads to byte-addressed memory over a valid/ready request channel and accepts in-order responses.
- Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready channel.
- Supports redirects (branch, call, return) and discards any stale in-flight responses.

---
 rtl/tinker_fetch_queue_if.sv | 35 +++
 rtl/tinker_fetch_queue.sv | 136 +++++++++++++
 tb/tb_tinker_fetch_queue.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinker_fetch_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tinker_fetch_queue_if
//  Description : Memory request/response and decode hand-off channels of the
//                Tinker instruction-fetch queue.
//  Revision    : 1.0  initial release
// ============================================================================
interface tinker_fetch_queue_if;
    // Memory read request channel
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    // Memory read response channel (in order, at most one per cycle)
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    // Decode channel
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [63:0] instr_pc;

    // The fetch queue itself
    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready
    );

    // Memory system and decode unit around the fetch queue
    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/tinker_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tinker_fetch_queue
//  Description : Prefetching fetch front end. Issues sequential 4-byte reads,
//                buffers {pc, instr} pairs in a DEPTH-entry FIFO for decode,
//                and squashes stale responses after a redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module tinker_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 halt,
    input  wire logic                 redirect_valid,
    input  wire logic [63:0]          redirect_pc,
    tinker_fetch_queue_if.master      bus,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // Credit limit, one bit wider than the counters so occupancy + inflight fits
    localparam logic [c_CNT_W:0] c_CREDIT_LIMIT = (c_CNT_W + 1)'(DEPTH);

    // Architectural state
    logic [63:0]        r_fetch_pc;
    logic [63:0]        r_rsp_pc;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_discard;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [63:0]        r_pc_mem   [DEPTH];
    logic [31:0]        r_data_mem [DEPTH];

    // Per-cycle events
    logic [c_CNT_W:0]   w_credit_sum;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_rsp_accept;
    logic               w_enq;
    logic               w_head_valid;
    logic               w_deq;
    logic [c_CNT_W-1:0] w_inflight_next;

    // Outstanding requests plus buffered entries never exceed DEPTH, so an
    // accepted response always has a free FIFO slot.
    assign w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_req_valid  = !reset && !halt && !redirect_valid && (w_credit_sum < c_CREDIT_LIMIT);
    assign w_req_fire   = w_req_valid && bus.mem_req_ready;

    // A response with nothing outstanding is a protocol violation and ignored
    assign w_rsp_accept = bus.mem_rsp_valid && (r_inflight != '0);
    // Responses in a redirect cycle, or owed to an earlier redirect, are dropped
    assign w_enq        = w_rsp_accept && !redirect_valid && (r_discard == '0);

    assign w_head_valid = (r_count != '0);
    assign w_deq        = w_head_valid && bus.instr_ready;

    assign w_inflight_next = r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(w_rsp_accept);

    // Outputs: head data is zeroed while the FIFO is empty
    assign bus.mem_req_valid = w_req_valid;
    assign bus.mem_req_addr  = r_fetch_pc;
    assign bus.instr_valid   = w_head_valid;
    assign bus.instr_data    = w_head_valid ? r_data_mem[r_rd_ptr] : 32'd0;
    assign bus.instr_pc      = w_head_valid ? r_pc_mem[r_rd_ptr]   : 64'd0;
    assign occupancy         = r_count;

    // Track outstanding requests and how many of them belong to a squashed stream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (redirect_valid) begin
                r_discard <= w_inflight_next;
            end else if (w_rsp_accept && (r_discard != '0)) begin
                r_discard <= r_discard - c_CNT_W'(1);
            end
        end
    end

    // Request and response program counters; a redirect reloads both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rsp_pc   <= redirect_pc;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 64'd4;
            end
            if (w_enq) begin
                r_rsp_pc <= r_rsp_pc + 64'd4;
            end
        end
    end

    // FIFO pointers and entry count; a redirect empties the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
        end
    end

    // FIFO storage; written only on enqueue, read through the head pointer
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
            r_data_mem[r_wr_ptr] <= bus.mem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tinker_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tinker_fetch_queue
//  Description : Self-checking bench for tinker_fetch_queue: a latency-
//                configurable in-order memory, a decode sink, and a
//                queue-based reference model of the instruction stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tinker_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [2:0]  occupancy;

    tinker_fetch_queue_if bus ();

    tinker_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] data; } entry_t;
    typedef struct { logic [63:0] addr; int due; int epoch; } req_t;

    // Reference model: expected decode queue, outstanding memory reads,
    // request stream position and redirect epoch.
    entry_t      mq[$];
    req_t        pend[$];
    int          m_inflight;
    int          m_epoch;
    logic [63:0] m_fetch_pc;

    int cyc, lat, rdy_pct, rsp_pct;
    int errors, checks;

    // Sampled DUT outputs and model expectations for the current cycle
    logic        s_req_valid, s_ivalid;
    logic [63:0] s_addr, s_ipc;
    logic [31:0] s_idata;
    logic [2:0]  s_occ;
    logic        e_req_valid, e_ivalid;
    logic [63:0] e_addr, e_ipc;
    logic [31:0] e_idata;
    int          e_occ;

    // Memory contents: a fixed scramble of the byte address
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A3C_96E1;
    endfunction

    // One clock cycle: drive memory, sample at negedge, advance the model
    task automatic tick();
        req_t rq;
        bus.mem_req_ready = ($urandom_range(99) < rdy_pct);
        if (pend.size() != 0 && pend[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = word_at(pend[0].addr);
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = $urandom;
        end
        if (reset) begin
            mq.delete();
            m_inflight = 0;
            m_fetch_pc = RESET_PC;
            m_epoch++;
        end
        e_req_valid = !reset && !halt && !redirect_valid && ((mq.size() + m_inflight) < DEPTH);
        e_addr      = m_fetch_pc;
        e_ivalid    = (mq.size() != 0);
        e_ipc       = e_ivalid ? mq[0].pc : 64'd0;
        e_idata     = e_ivalid ? mq[0].data : 32'd0;
        e_occ       = mq.size();

        @(negedge clk);
        s_req_valid = bus.mem_req_valid;
        s_addr      = bus.mem_req_addr;
        s_ivalid    = bus.instr_valid;
        s_ipc       = bus.instr_pc;
        s_idata     = bus.instr_data;
        s_occ       = occupancy;

        if (!reset && mq.size() != 0 && bus.instr_ready) begin
            void'(mq.pop_front());
        end
        if (bus.mem_rsp_valid) begin
            rq = pend.pop_front();
            if (!reset && m_inflight > 0) begin
                m_inflight--;
                if (rq.epoch == m_epoch && !redirect_valid) begin
                    mq.push_back('{rq.addr, word_at(rq.addr)});
                end
            end
        end
        if (!reset && redirect_valid) begin
            mq.delete();
            m_epoch++;
            m_fetch_pc = redirect_pc;
        end
        if (s_req_valid && bus.mem_req_ready) begin
            pend.push_back('{s_addr, cyc + lat, m_epoch});
            if (!reset) m_inflight++;
            if (!redirect_valid) m_fetch_pc = m_fetch_pc + 64'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
        tick();
        pend.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        bus.instr_ready = 1'b1; lat = 1; rdy_pct = 100; rsp_pct = 100;
        tick(); tick();
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", s_req_valid); end
        checks++; if (s_ivalid !== 1'b0 || s_occ !== 3'd0) begin errors++; $display("FAIL reset_empty: valid %b occ %0d want 0/0", s_ivalid, s_occ); end
        checks++; if (s_idata !== 32'd0 || s_ipc !== 64'd0) begin errors++; $display("FAIL reset_head: data %h pc %h want 0/0", s_idata, s_ipc); end
        reset = 1'b0;
        tick();
        checks++; if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("FAIL first_req: valid %b addr %h want 1/%h", s_req_valid, s_addr, RESET_PC); end
        tick();
        checks++; if (s_ivalid !== 1'b0) begin errors++; $display("FAIL no_bypass: valid %b want 0", s_ivalid); end
        tick();
        checks++; if (s_ivalid !== 1'b1 || s_ipc !== RESET_PC || s_idata !== word_at(RESET_PC)) begin
            errors++; $display("FAIL first_instr: valid %b pc %h data %h want 1/%h/%h", s_ivalid, s_ipc, s_idata, RESET_PC, word_at(RESET_PC));
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++; if (s_ivalid !== 1'b1 || s_ipc !== RESET_PC + 64'(4 * k)) begin
                errors++; $display("FAIL stream_%0d: valid %b pc %h want 1/%h", k, s_ivalid, s_ipc, RESET_PC + 64'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] addrs[$];
        logic [63:0] outs[$];
        logic [63:0] got, want;
        bit          seen;
        do_reset();
        bus.instr_ready = 1'b0; lat = 1; rdy_pct = 100; rsp_pct = 100;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_req_valid) addrs.push_back(s_addr);
        end
        checks++; if (addrs.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", addrs.size()); end
        for (int k = 0; k < 4; k++) begin
            got  = (k < addrs.size()) ? addrs[k] : '1;
            want = RESET_PC + 64'(4 * k);
            checks++; if (got !== want) begin errors++; $display("FAIL bp_req_addr_%0d: got %h want %h", k, got, want); end
        end
        checks++; if (s_req_valid !== 1'b0 || s_occ !== 3'd4) begin errors++; $display("FAIL bp_full: req %b occ %0d want 0/4", s_req_valid, s_occ); end
        bus.instr_ready = 1'b1;
        seen = 1'b0; got = '1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_ivalid) outs.push_back(s_ipc);
            if (s_req_valid && !seen) begin seen = 1'b1; got = s_addr; end
        end
        for (int k = 0; k < 4; k++) begin
            want = RESET_PC + 64'(4 * k);
            checks++; if (k >= outs.size() || outs[k] !== want) begin errors++; $display("FAIL bp_drain_%0d: got %h want %h", k, (k < outs.size()) ? outs[k] : '1, want); end
        end
        checks++; if (got !== 64'h2010) begin errors++; $display("FAIL bp_resume: got %h want 2010", got); end
    endtask

    task automatic test_redirect_stale();
        bit          seen, stale;
        logic [63:0] first_pc;
        logic [31:0] first_data;
        do_reset();
        bus.instr_ready = 1'b1; lat = 3; rdy_pct = 100; rsp_pct = 100;
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        tick();
        redirect_valid = 1'b0;
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_blocked: got %b want 0", s_req_valid); end
        tick();
        checks++; if (s_req_valid !== 1'b1 || s_addr !== 64'h3000) begin errors++; $display("FAIL redir_next_req: valid %b addr %h want 1/3000", s_req_valid, s_addr); end
        seen = 1'b0; stale = 1'b0; first_pc = '1; first_data = '1;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (s_ivalid) begin seen = 1'b1; first_pc = s_ipc; first_data = s_idata; end
        end
        if (seen && first_pc < 64'h3000) stale = 1'b1;
        checks++; if (!seen || stale || first_pc !== 64'h3000 || first_data !== word_at(64'h3000)) begin
            errors++; $display("FAIL redir_first_instr: pc %h data %h want 3000/%h", first_pc, first_data, word_at(64'h3000));
        end
    endtask

    task automatic test_redirect_full();
        bit          leak, seen;
        logic [63:0] first_pc;
        do_reset();
        bus.instr_ready = 1'b0; lat = 1; rdy_pct = 100; rsp_pct = 100;
        tick(); tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 64'h4000;
        tick();
        redirect_valid = 1'b0;
        checks++; if (s_occ !== 3'd3) begin errors++; $display("FAIL rf_pre_occ: got %0d want 3", s_occ); end
        tick();
        checks++; if (s_occ !== 3'd0 || s_ivalid !== 1'b0) begin errors++; $display("FAIL rf_flushed: occ %0d valid %b want 0/0", s_occ, s_ivalid); end
        bus.instr_ready = 1'b1;
        leak = 1'b0; seen = 1'b0; first_pc = '1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (s_ivalid) begin
                if (!seen) begin seen = 1'b1; first_pc = s_ipc; end
                if (s_ipc === 64'h200C || s_idata === word_at(64'h200C)) leak = 1'b1;
            end
        end
        checks++; if (leak) begin errors++; $display("FAIL rf_leak: got stale 200c entry want none"); end
        checks++; if (first_pc !== 64'h4000) begin errors++; $display("FAIL rf_first_pc: got %h want 4000", first_pc); end
    endtask

    task automatic test_halt();
        int          nreq;
        logic [63:0] outs[$];
        do_reset();
        bus.instr_ready = 1'b1; lat = 3; rdy_pct = 100; rsp_pct = 100;
        tick(); tick();
        halt = 1'b1; nreq = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (s_req_valid) nreq++;
            if (s_ivalid) outs.push_back(s_ipc);
        end
        checks++; if (nreq != 0) begin errors++; $display("FAIL halt_no_req: got %0d want 0", nreq); end
        checks++; if (outs.size() != 2) begin errors++; $display("FAIL halt_drain_count: got %0d want 2", outs.size()); end
        checks++; if (outs.size() < 2 || outs[0] !== 64'h2000 || outs[1] !== 64'h2004) begin
            errors++; $display("FAIL halt_drain_pcs: got %h %h want 2000 2004", (outs.size() > 0) ? outs[0] : '1, (outs.size() > 1) ? outs[1] : '1);
        end
        halt = 1'b0;
        tick();
        checks++; if (s_req_valid !== 1'b1 || s_addr !== 64'h2008) begin errors++; $display("FAIL halt_resume: valid %b addr %h want 1/2008", s_req_valid, s_addr); end
    endtask

    task automatic test_reset_mid();
        int          bad;
        bit          seen;
        logic [63:0] first_pc;
        logic [31:0] first_data;
        do_reset();
        bus.instr_ready = 1'b1; lat = 3; rdy_pct = 100; rsp_pct = 100;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if (s_req_valid !== 1'b0 || s_ivalid !== 1'b0 || s_occ !== 3'd0) begin
            errors++; $display("FAIL mid_reset_outs: req %b valid %b occ %0d want 0/0/0", s_req_valid, s_ivalid, s_occ);
        end
        reset = 1'b0; halt = 1'b1; bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (s_ivalid !== 1'b0 || s_occ !== 3'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_reset_late_rsp: got %0d cycles non-empty want 0", bad); end
        halt = 1'b0;
        tick();
        checks++; if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("FAIL mid_reset_req: valid %b addr %h want 1/%h", s_req_valid, s_addr, RESET_PC); end
        seen = 1'b0; first_pc = '1; first_data = '1;
        for (int k = 0; k < 15 && !seen; k++) begin
            tick();
            if (s_ivalid) begin seen = 1'b1; first_pc = s_ipc; first_data = s_idata; end
        end
        checks++; if (first_pc !== RESET_PC || first_data !== word_at(RESET_PC)) begin
            errors++; $display("FAIL mid_reset_first: pc %h data %h want %h/%h", first_pc, first_data, RESET_PC, word_at(RESET_PC));
        end
    endtask

    task automatic test_random();
        do_reset();
        lat = 2; rdy_pct = 70; rsp_pct = 70;
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) lat = 1 + $urandom_range(3);
            halt            = ($urandom_range(99) < 10);
            bus.instr_ready = ($urandom_range(99) < 60);
            redirect_valid  = ($urandom_range(99) < 4);
            case ($urandom_range(2))
                0:       redirect_pc = {$urandom, $urandom};
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3) * 4);
                default: redirect_pc = 64'h1000 + 64'($urandom_range(255) * 4);
            endcase
            tick();
            checks++; if (s_req_valid !== e_req_valid) begin errors++; $display("FAIL rnd_req_valid @%0d: got %b want %b", cyc, s_req_valid, e_req_valid); end
            if (e_req_valid) begin
                checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rnd_req_addr @%0d: got %h want %h", cyc, s_addr, e_addr); end
            end
            checks++; if (s_ivalid !== e_ivalid) begin errors++; $display("FAIL rnd_instr_valid @%0d: got %b want %b", cyc, s_ivalid, e_ivalid); end
            if (e_ivalid) begin
                checks++; if (s_ipc !== e_ipc || s_idata !== e_idata) begin
                    errors++; $display("FAIL rnd_head @%0d: pc %h data %h want %h/%h", cyc, s_ipc, s_idata, e_ipc, e_idata);
                end
            end
            checks++; if (int'(s_occ) != e_occ) begin errors++; $display("FAIL rnd_occupancy @%0d: got %0d want %0d", cyc, s_occ, e_occ); end
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        m_inflight = 0; m_epoch = 0; m_fetch_pc = RESET_PC;
        reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        bus.instr_ready = 1'b0; bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        lat = 1; rdy_pct = 100; rsp_pct = 100;
        test_reset();
        test_backpressure();
        test_redirect_stale();
        test_redirect_full();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
